cog_centroid_divider: RTL

Downstream stage of the CoG pipeline: consumes the per-figure accumulator beats emitted by the CoG top block's transmitter (sum of I·coord, sum of I, start point) and divides them into a fixed-point centre-of-gravity coordinate. It is a buffered, iterative restoring divider with a full AXI-Stream master output. A small input FIFO absorbs beats, because the upstream CoG stream has no backpressure.

---
 rtl/cog_centroid_divider.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cog_centroid_divider.sv
// cog_centroid_divider: turns per-figure CoG accumulator beats into a
// fixed-point centre-of-gravity coordinate using an iterative restoring
// divider behind a small first-word-fall-through input FIFO.
// Optional build macro: COG_DIV_ROUND_EN (round half up instead of truncation).
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a FIFO head; latches and pops it when present
//   DIV    | one restoring division iteration per cycle, 30+FRAC_BITS total
//   ADD    | adds the scaled start point to the quotient, saturates to 16 b
//   OUT    | holds the result on m_axis until the downstream handshake
module cog_centroid_divider #(
   parameter int DATA_WIDTH = 8,
   parameter int FRAC_BITS  = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                    i_sys_clk,
   input  logic                    i_sys_areset,
   input  logic [8*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tuser,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [31:0]             m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tuser,
   output logic                    m_axis_tlast,
   output logic                    o_overflow
);

   localparam int IW = 8 * DATA_WIDTH;
   localparam int EW = IW + 2;
   localparam int DW = 30 + FRAC_BITS;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_ADD, S_OUT} state_t;

   state_t state, state_next;

   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, push, pop;

   logic [EW-1:0] head;
   logic [29:0]   head_smc;
   logic [22:0]   head_si;
   logic [10:0]   head_sp;
   logic          head_user, head_last;

   logic [DW-1:0] dvd, dvd_init, quo;
   logic [22:0]   divisor, rem, rem_next;
   logic [23:0]   rem_shift;
   logic          qbit;
   logic [CW-1:0] cnt;
   logic [10:0]   sp_r;
   logic [35:0]   sum;
   logic [31:0]   out_data;
   logic          out_user, out_last;

   assign full          = (count == (AW+1)'(FIFO_DEPTH));
   assign empty         = (count == '0);
   // a full FIFO still accepts a beat when the FSM frees a slot in the same cycle
   assign push          = s_axis_tvalid && (!full || pop);
   assign s_axis_tready = !full;

   assign head      = fifo_mem[rd_ptr];
   assign head_smc  = head[29:0];
   assign head_si   = head[52:30];
   assign head_sp   = head[63:53];
   assign head_user = head[64];
   assign head_last = head[65];

   // FIFO storage; contents are don't-care until the count says otherwise
   always_ff @(posedge i_sys_clk) begin
      if (push) fifo_mem[wr_ptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
      if (i_sys_areset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (s_axis_tvalid && full && !pop) o_overflow <= 1'b1;
      end
   end

   // initial dividend; the rounded form clamps instead of wrapping past DW bits
`ifdef COG_DIV_ROUND_EN
   logic [DW:0] dvd_sum;
   always_comb begin
      dvd_sum  = ((DW+1)'(head_smc) << FRAC_BITS) + (DW+1)'(head_si >> 1);
      dvd_init = dvd_sum[DW] ? '1 : dvd_sum[DW-1:0];
   end
`else
   always_comb begin
      dvd_init = DW'(head_smc) << FRAC_BITS;
   end
`endif

   // one restoring step: shift in the next dividend bit and trial-subtract
   always_comb begin
      rem_shift = {rem, dvd[DW-1]};
      qbit      = (rem_shift >= {1'b0, divisor});
      rem_next  = qbit ? 23'(rem_shift - {1'b0, divisor}) : rem_shift[22:0];
      sum       = (36'(sp_r) << FRAC_BITS) + 36'(quo);
   end

   // state register
   always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
      if (i_sys_areset) state <= S_IDLE;
      else              state <= state_next;
   end

   // next-state and FIFO pop decision
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = (head_si != '0) ? S_DIV : S_OUT;
            end
         end
         S_DIV:   if (cnt == CW'(1)) state_next = S_ADD;
         S_ADD:   state_next = S_OUT;
         S_OUT:   if (m_axis_tready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // division datapath and output holding registers
   always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
      if (i_sys_areset) begin
         dvd      <= '0;
         quo      <= '0;
         rem      <= '0;
         divisor  <= '0;
         cnt      <= '0;
         sp_r     <= '0;
         out_data <= '0;
         out_user <= 1'b0;
         out_last <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  dvd      <= dvd_init;
                  quo      <= '0;
                  rem      <= '0;
                  divisor  <= head_si;
                  cnt      <= CW'(DW);
                  sp_r     <= head_sp;
                  out_user <= head_user;
                  out_last <= head_last;
                  if (head_si == '0) out_data <= '0;
               end
            end
            S_DIV: begin
               rem <= rem_next;
               quo <= {quo[DW-2:0], qbit};
               dvd <= {dvd[DW-2:0], 1'b0};
               cnt <= cnt - CW'(1);
            end
            S_ADD: begin
               if (|sum[35:16]) out_data <= {14'd0, 2'b11, 16'hFFFF};
               else             out_data <= {14'd0, 2'b01, sum[15:0]};
            end
            default: ;
         endcase
      end
   end

   assign m_axis_tvalid = (state == S_OUT);
   assign m_axis_tdata  = out_data;
   assign m_axis_tuser  = out_user;
   assign m_axis_tlast  = out_last;

endmodule
